// File: rtl/data_mem_port.sv
// data_mem_port -- byte-addressable data memory port for the load/store unit.
//
// Stores write the array on the edge that samples the request; loads return
// an extended result one cycle later. Misaligned or reserved accesses are
// rejected and flagged with a one-cycle misaligned pulse.
//
// Ports:
//   CLK         clock, all state on the rising edge
//   RST         synchronous active-high reset (array contents are kept)
//   memory_en   request strobe, one request per cycle while high
//   store_size  00 byte store, 01 half store, 10 word store, 11 load
//   funct3      load kind: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
//   addr        byte address; word index wraps modulo DEPTH_WORDS
//   wdata       store data, low byte/half/word used
//   rdata       load result, held until the next load response
//   rvalid      one-cycle pulse when rdata carries a new load response
//   misaligned  one-cycle pulse for a rejected access
//   busy        high while a load response is presented (state RESP)
module data_mem_port #(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        memory_en,
  input  logic [1:0]  store_size,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        misaligned,
  output logic        busy
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic {IDLE, RESP} state_t;

  state_t        state;
  logic [31:0]   mem [DEPTH_WORDS];
  logic [31:0]   rd_word;
  logic [2:0]    ld_f3;
  logic [1:0]    ld_lane;
  logic          ld_err;

  logic [AW-1:0] idx;
  logic          is_load;
  logic [1:0]    acc_size;
  logic          reserved;
  logic          bad;
  logic          ld_go;
  logic          st_go;
  logic [3:0]    be;
  logic [31:0]   wlane;
  logic [31:0]   shifted;
  logic          unused_addr;

  assign idx         = addr[AW+1:2];
  assign unused_addr = ^addr[31:AW+2];

  // Loads take their access width from funct3[1:0], stores from store_size.
  assign is_load  = (store_size == 2'b11);
  assign acc_size = is_load ? funct3[1:0] : store_size;
  assign reserved = is_load && ((funct3[1:0] == 2'b11) || (funct3[2:1] == 2'b11));
  assign bad      = reserved
                 || ((acc_size == 2'b01) && addr[0])
                 || ((acc_size == 2'b10) && (addr[1:0] != 2'b00));
  assign ld_go    = memory_en && is_load && !bad;
  assign st_go    = memory_en && !is_load && !bad;

  always_comb begin
    be    = '0;
    wlane = wdata;
    case (store_size)
      2'b00: begin
        be[addr[1:0]] = 1'b1;
        wlane         = {4{wdata[7:0]}};
      end
      2'b01: begin
        be    = addr[1] ? 4'b1100 : 4'b0011;
        wlane = {2{wdata[15:0]}};
      end
      2'b10:   be = '1;
      default: be = '0;
    endcase
  end

  // Byte-enabled write port.
  always_ff @(posedge CLK) begin
    if (!RST && st_go) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wlane[8*b +: 8];
      end
    end
  end

  // Synchronous read port; the register only loads on an accepted load so
  // the previous response is held across stores and idle cycles.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_word <= '0;
    end else if (ld_go) begin
      rd_word <= mem[idx];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      rvalid     <= 1'b0;
      misaligned <= 1'b0;
      ld_err     <= 1'b0;
      ld_f3      <= 3'b010;
      ld_lane    <= 2'b00;
    end else begin
      rvalid     <= 1'b0;
      misaligned <= 1'b0;
      if (memory_en && is_load) begin
        state      <= RESP;
        rvalid     <= 1'b1;
        misaligned <= bad;
        ld_err     <= bad;
        ld_f3      <= funct3;
        ld_lane    <= addr[1:0];
      end else begin
        state <= IDLE;
        if (memory_en) misaligned <= bad;
      end
    end
  end

  assign busy = (state == RESP);

  // Extraction runs after the RAM output register using the lane and kind
  // latched with the request; reset values (LW, lane 0, zero word) give 0.
  assign shifted = rd_word >> {ld_lane, 3'b000};

  always_comb begin
    case (ld_f3)
      3'b000:  rdata = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  rdata = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  rdata = {24'h0, shifted[7:0]};
      3'b101:  rdata = {16'h0, shifted[15:0]};
      default: rdata = rd_word;
    endcase
    if (ld_err) rdata = '0;
  end

endmodule

// File: doc/data_mem_port.md
DATA_MEM_PORT -- requirements
Module: data_mem_port

Interface
REQ-001 Parameter: DEPTH_WORDS, default 1024, number of 32-bit words in the data array; power of two, at least 4.
REQ-002 CLK  input  1  clock; the block has one clock and all state updates on its rising edge.
REQ-003 RST  input  1  reset, synchronous and active-high.
REQ-004 memory_en  input  1  request strobe from the controller; one request per cycle while high.
REQ-005 store_size  input  2  00 = byte store, 01 = half store, 10 = word store, 11 = load.
REQ-006 funct3  input  3  load kind when store_size = 11: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-007 addr  input  32  byte address from the ALU result.
REQ-008 wdata  input  32  store data (rs2); the low byte, low half or full word is used.
REQ-009 rdata  output  32  load result, sign- or zero-extended.
REQ-010 rvalid  output  1  one-cycle pulse marking rdata as updated.
REQ-011 misaligned  output  1  one-cycle pulse flagging a rejected misaligned or reserved access.
REQ-012 busy  output  1  high while a load response is pending (state RESP).

Function
REQ-013 Word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; higher address bits are ignored, so accesses wrap modulo the array size.
REQ-014 A store SHALL write in the same rising edge on which memory_en=1 is sampled.
- Byte stores write lane addr[1:0].
- Half stores write lanes {addr[1],0}+{0,1}.
- Word stores write all four lanes.
- Unselected lanes keep their value.
REQ-015 A store SHALL NOT raise rvalid, and it SHALL leave rdata unchanged.
REQ-016 A load sampled at edge N SHALL update rdata and pulse rvalid in cycle N+1, matching the controller's two-cycle load (stall cycle, then write-back cycle).
REQ-017 The FSM SHALL have two states.
- IDLE to RESP on a valid load.
- RESP to IDLE when memory_en=0 or a store is sampled.
- RESP to RESP when another valid load is sampled (back-to-back).
REQ-018 busy SHALL equal (state == RESP).
REQ-019 Load extraction SHALL select the byte or half by addr[1:0] latched at request time.
- LB and LH sign-extend from bit 7 or 15.
- LBU and LHU zero-extend.
- LW returns the full word.
REQ-020 Misaligned access SHALL be detected as follows.
- Half access with addr[0]=1.
- Word access with addr[1:0]≠00.
- For stores: no lanes are written and misaligned pulses in cycle N+1.
- For loads: rdata=0, rvalid=1 and misaligned=1 in cycle N+1.
REQ-021 Reserved load funct3 values (011, 110, 111) SHALL be treated as misaligned loads: rdata=0, rvalid=1, misaligned=1.
REQ-022 A load to the word written by a store on the immediately preceding edge SHALL return the newly written data.
REQ-023 rdata SHALL hold its value until the next load response; rvalid and misaligned SHALL be high for exactly one cycle per request.
REQ-024 When memory_en=0, the array, rdata and the FSM state SHALL be unchanged, except for the RESP-to-IDLE return in REQ-017.
REQ-025 The array SHALL be inferable as block RAM: one synchronous read port and one byte-enabled write port.

Reset
REQ-026 While RST=1, the block SHALL:
- set state to IDLE;
- set rdata=0, rvalid=0, misaligned=0, busy=0;
- ignore memory_en, so no array write occurs.
REQ-027 Array contents SHALL NOT be cleared by RST.
REQ-028 RST asserted in a RESP cycle SHALL cancel the pending response: no rvalid pulse follows, and rdata=0 in the next cycle.
REQ-029 Array contents after power-up are undefined; benches SHALL write before reading.

Verification
REQ-030 Store word 0xDEADBEEF to addr 0x10, then LW at 0x10 -> one cycle after the load, rdata=0xDEADBEEF, rvalid=1, busy was 1 during the wait.
REQ-031 Store byte 0x80 to 0x13, then LB at 0x13 -> rdata=0xFFFFFF80; then LBU at 0x13 -> rdata=0x00000080; LW at 0x10 -> 0x80ADBEEF.
REQ-032 Store half 0x1234 to 0x11 -> misaligned pulse, word at 0x10 unchanged; LH at 0x12 with funct3=001 -> 0xFFFF80AD.
REQ-033 Back-to-back LW at 0x10 then 0x14 on consecutive edges -> rvalid high two consecutive cycles, with the data arriving in request order.
REQ-034 LW issued, RST=1 on the following edge -> rvalid stays 0, rdata=0; after reset, LW at 0x10 still returns 0x80ADBEEF.
REQ-035 Word store to addr 0x10+4*DEPTH_WORDS, then LW at 0x10 -> returns the stored value, confirming wrap-around.
